// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant scheduler: default sizes, FSM encoding
// and the one-hot helper used to build the grant vector.
package arb_pkg;

  localparam int NUM_REQ_DEF = 16;
  localparam int IDX_W_DEF   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
    logic [NUM_REQ_DEF-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational lowest-index-first priority encoder with a 'found' flag.
module prio_enc #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_REQ-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: holds a one-hot grant until the owner releases.
// Optional forced revoke after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_scheduler
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_DEF || (1 << IDX_W) != NUM_REQ || MAX_HOLD < 2) begin : g_param_chk
    $error("rr_grant_scheduler: unsupported NUM_REQ/IDX_W/MAX_HOLD combination");
  end

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       ptr, ptr_nxt;
  logic [NUM_REQ-1:0]     gnt_nxt;
  logic [IDX_W-1:0]       gnt_idx_nxt;
  logic [NUM_REQ-1:0]     mask;
  logic [IDX_W-1:0]       m_idx, u_idx, win_idx;
  logic                   m_found, u_found;
  logic [NUM_REQ_DEF-1:0] win_oh_full;
  logic                   owner_rel;
  logic                   rearb;
  logic                   revoke;

  // Bits at or above the rotate pointer form the higher-priority window.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(ptr));
    end
  end

  prio_enc #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_enc_masked (
    .vec   (req & mask),
    .idx   (m_idx),
    .found (m_found)
  );

  prio_enc #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_enc_unmasked (
    .vec   (req),
    .idx   (u_idx),
    .found (u_found)
  );

  assign win_idx     = m_found ? m_idx : u_idx;
  assign win_oh_full = onehot(IDX_W_DEF'(win_idx));
  assign owner_rel   = (state == ST_GRANT) && !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             timeout_q;

  // ptr already sits just past the owner, so a revoked owner is naturally scanned last.
  assign revoke = (state == ST_GRANT) && req[gnt_idx] && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (rearb) begin
      hold_cnt_nxt = '0;
    end else if (state == ST_GRANT) begin
      hold_cnt_nxt = hold_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_nxt;
      timeout_q <= revoke;
    end
  end

  assign timeout = timeout_q;
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign rearb = (state == ST_IDLE) || owner_rel || revoke;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    gnt_idx_nxt = gnt_idx;
    if (rearb) begin
      if (u_found) begin
        state_nxt   = ST_GRANT;
        gnt_nxt     = win_oh_full[NUM_REQ-1:0];
        gnt_idx_nxt = win_idx;
        ptr_nxt     = win_idx + IDX_W'(1);
      end else begin
        state_nxt   = ST_IDLE;
        gnt_nxt     = '0;
        gnt_idx_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= gnt_idx_nxt;
    end
  end

  assign gnt_valid = (state == ST_GRANT);

endmodule
